// File: rtl/gray_window_compositor_if.sv
// Frame buffer read port between the compositor (master) and the image RAM (slave).
interface gray_window_compositor_if #(
   parameter int ADDR_W = 17,
   parameter int PIX_W  = 4
);
   logic [ADDR_W-1:0] raddr_out;
   logic              ren_out;
   logic [PIX_W-1:0]  rdata_in;

   modport master (output raddr_out, output ren_out, input rdata_in);
   modport slave  (input raddr_out, input ren_out, output rdata_in);
endinterface

// File: rtl/gray_window_compositor.sv
// Places a grayscale frame-buffer image at a frame-synchronous window on the VGA raster,
// with integer scale, mirror, border, sprite overlay and a sync delay matched to the RAM.
module gray_window_compositor #(
   parameter int               H_ACTIVE    = 1024,
   parameter int               V_ACTIVE    = 768,
   parameter int               IMG_W       = 240,
   parameter int               IMG_H       = 320,
   parameter int               ADDR_W      = 17,
   parameter int               PIX_W       = 4,
   parameter int               RAM_LAT     = 2,
   parameter int               SCALE_MAX   = 2,
   parameter logic [PIX_W-1:0] BORDER_GRAY = 4'hF
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic [10:0]          hcount_in,
   input  logic [9:0]           vcount_in,
   input  logic                 hsync_in,
   input  logic                 vsync_in,
   input  logic                 blank_in,
   input  logic [10:0]          x0_in,
   input  logic [9:0]           y0_in,
   input  logic [1:0]           scale_in,
   input  logic                 mirror_in,
   input  logic                 border_en_in,
   input  logic [3*PIX_W-1:0]   overlay_in,
   input  logic                 overlay_valid_in,
   gray_window_compositor_if.master fb,
   output logic [PIX_W-1:0]     r_out,
   output logic [PIX_W-1:0]     g_out,
   output logic [PIX_W-1:0]     b_out,
   output logic                 hsync_out,
   output logic                 vsync_out,
   output logic                 cfg_applied_out,
   output logic [15:0]          frame_count_out
);

   localparam int         DW    = 3*PIX_W + 6;
   localparam logic [1:0] S_MAX = 2'(SCALE_MAX);

   // Delay-line word: {overlay, vsync, hsync, blank, overlay_valid, border, in_win}
   localparam int B_WIN = 0;
   localparam int B_BRD = 1;
   localparam int B_OVV = 2;
   localparam int B_BLK = 3;
   localparam int B_HS  = 4;
   localparam int B_VS  = 5;
   localparam int B_OVL = 6;

   logic [10:0]       r_x0;
   logic [9:0]        r_y0;
   logic [1:0]        r_scale;
   logic              r_mirror;
   logic              r_vs_d;
   logic              r_cfg_applied;
   logic [15:0]       r_frame_count;

   logic [ADDR_W-1:0] r_raddr;
   logic              r_ren;
   logic [DW-1:0]     r_a;
   logic [DW-1:0]     r_dly [RAM_LAT];
   logic [3*PIX_W-1:0] r_rgb;
   logic              r_hs_o;
   logic              r_vs_o;

   logic              w_vs_rise;
   logic [1:0]        w_scale_c;
   logic [11:0]       w_h, w_v, w_x0, w_y0, w_x_end, w_y_end;
   logic [11:0]       w_dx, w_dy, w_u, w_u_m, w_v_idx;
   logic              w_on_screen, w_in_x, w_in_y, w_in_win;
   logic              w_ring_x, w_ring_y, w_border;
   logic [ADDR_W-1:0] w_addr;
   logic [DW-1:0]     w_a_next;
   logic [DW-1:0]     w_d;

   assign w_vs_rise = vsync_in & ~r_vs_d;
   assign w_scale_c = (scale_in > S_MAX) ? S_MAX : scale_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_x0          <= '0;
         r_y0          <= '0;
         r_scale       <= '0;
         r_mirror      <= 1'b0;
         r_vs_d        <= 1'b0;
         r_cfg_applied <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_vs_d        <= vsync_in;
         r_cfg_applied <= w_vs_rise;
         if (w_vs_rise) begin
            r_x0          <= x0_in;
            r_y0          <= y0_in;
            r_scale       <= w_scale_c;
            r_mirror      <= mirror_in;
            r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

   // 12-bit window math: the largest window end (2047 + 240*4) never wraps.
   assign w_h       = {1'b0, hcount_in};
   assign w_v       = {2'b0, vcount_in};
   assign w_x0      = {1'b0, r_x0};
   assign w_y0      = {2'b0, r_y0};
   assign w_x_end   = w_x0 + (12'(IMG_W) << r_scale);
   assign w_y_end   = w_y0 + (12'(IMG_H) << r_scale);

   assign w_on_screen = (w_h < 12'(H_ACTIVE)) && (w_v < 12'(V_ACTIVE)) && !blank_in;
   assign w_in_x      = (w_h >= w_x0) && (w_h < w_x_end);
   assign w_in_y      = (w_v >= w_y0) && (w_v < w_y_end);
   assign w_in_win    = w_in_x && w_in_y && w_on_screen;

   // The ring is the window grown by one pixel on every side, minus the window itself.
   assign w_ring_x = (w_h + 12'd1 >= w_x0) && (w_h <= w_x_end);
   assign w_ring_y = (w_v + 12'd1 >= w_y0) && (w_v <= w_y_end);
   assign w_border = border_en_in && w_on_screen && !w_in_win && w_ring_x && w_ring_y;

   assign w_dx    = w_h - w_x0;
   assign w_dy    = w_v - w_y0;
   assign w_u     = w_dx >> r_scale;
   assign w_v_idx = w_dy >> r_scale;
   assign w_u_m   = r_mirror ? (12'(IMG_W - 1) - w_u) : w_u;
   assign w_addr  = ADDR_W'(w_v_idx) * ADDR_W'(IMG_W) + ADDR_W'(w_u_m);

   assign w_a_next = {overlay_in, vsync_in, hsync_in, blank_in,
                      overlay_valid_in, w_border, w_in_win};

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_raddr <= '0;
         r_ren   <= 1'b0;
         r_a     <= '0;
         for (int i = 0; i < RAM_LAT; i++) r_dly[i] <= '0;
      end else begin
         r_ren <= w_in_win;
         if (w_in_win) r_raddr <= w_addr;
         r_a      <= w_a_next;
         r_dly[0] <= r_a;
         for (int i = 1; i < RAM_LAT; i++) r_dly[i] <= r_dly[i-1];
      end
   end

   assign w_d = r_dly[RAM_LAT-1];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_rgb  <= '0;
         r_hs_o <= 1'b0;
         r_vs_o <= 1'b0;
      end else begin
         r_hs_o <= w_d[B_HS];
         r_vs_o <= w_d[B_VS];
         if (w_d[B_BLK])
            r_rgb <= '0;
         else if (w_d[B_OVV])
            r_rgb <= w_d[B_OVL +: 3*PIX_W];
         else if (w_d[B_WIN])
            r_rgb <= {3{fb.rdata_in}};
         else if (w_d[B_BRD])
            r_rgb <= {3{BORDER_GRAY}};
         else
            r_rgb <= '0;
      end
   end

   assign fb.raddr_out      = r_raddr;
   assign fb.ren_out        = r_ren;
   assign r_out             = r_rgb[3*PIX_W-1:2*PIX_W];
   assign g_out             = r_rgb[2*PIX_W-1:PIX_W];
   assign b_out             = r_rgb[PIX_W-1:0];
   assign hsync_out         = r_hs_o;
   assign vsync_out         = r_vs_o;
   assign cfg_applied_out   = r_cfg_applied;
   assign frame_count_out   = r_frame_count;

endmodule

// File: tb/tb_gray_window_compositor.sv
// Directed bench for gray_window_compositor: a 2-cycle RAM returning addr[3:0] and a hand-driven raster.
module tb_gray_window_compositor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync, vsync, blank;
   logic [10:0] x0;
   logic [9:0]  y0;
   logic [1:0]  scale;
   logic        mirror, border_en;
   logic [11:0] overlay;
   logic        overlay_valid;
   logic [3:0]  r_o, g_o, b_o;
   logic        hs_o, vs_o, cfg_applied;
   logic [15:0] frame_count;
   logic [11:0] rgb;
   logic [3:0]  ram_p0, ram_p1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gray_window_compositor_if #(.ADDR_W(17), .PIX_W(4)) fb_if ();

   gray_window_compositor dut (
      .clk_in           (clk),
      .rst_n_in         (rst_n),
      .hcount_in        (hcount),
      .vcount_in        (vcount),
      .hsync_in         (hsync),
      .vsync_in         (vsync),
      .blank_in         (blank),
      .x0_in            (x0),
      .y0_in            (y0),
      .scale_in         (scale),
      .mirror_in        (mirror),
      .border_en_in     (border_en),
      .overlay_in       (overlay),
      .overlay_valid_in (overlay_valid),
      .fb               (fb_if),
      .r_out            (r_o),
      .g_out            (g_o),
      .b_out            (b_o),
      .hsync_out        (hs_o),
      .vsync_out        (vs_o),
      .cfg_applied_out  (cfg_applied),
      .frame_count_out  (frame_count)
   );

   // RAM model: data = addr[3:0], valid two cycles after the address.
   always_ff @(posedge clk) begin
      ram_p0 <= fb_if.raddr_out[3:0];
      ram_p1 <= ram_p0;
   end
   assign fb_if.rdata_in = ram_p1;
   assign rgb = {r_o, g_o, b_o};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one raster position, clock it in, and settle just after the edge.
   task automatic tick(input int h, input int v, input logic hs, input logic vs);
      hcount = 11'(h);
      vcount = 10'(v);
      hsync  = hs;
      vsync  = vs;
      blank  = (h >= 1024) || (v >= 768);
      @(posedge clk);
      #1;
   endtask

   task automatic new_frame(input logic [15:0] exp_fc);
      tick(1100, 780, 1'b0, 1'b0);
      tick(1100, 780, 1'b0, 1'b1);
      chk("cfg_pulse", cfg_applied, 1);
      chk("frame_count", frame_count, exp_fc);
      tick(1100, 780, 1'b0, 1'b1);
      chk("cfg_single", cfg_applied, 0);
      tick(1100, 780, 1'b0, 1'b0);
   endtask

   initial begin
      logic [11:0] pat;
      pat = 12'b0011_1001_0110;
      rst_n = 1'b0; x0 = '0; y0 = '0; scale = '0; mirror = 1'b0; border_en = 1'b0;
      overlay = 12'h5A3; overlay_valid = 1'b0;

      // Reset holds everything at zero, and a vsync edge under reset is ignored.
      tick(300, 300, 1'b1, 1'b1);
      tick(300, 300, 1'b1, 1'b1);
      chk("rst_rgb", rgb, 0);
      chk("rst_sync", {hs_o, vs_o}, 0);
      chk("rst_read", {fb_if.ren_out, fb_if.raddr_out}, 0);
      chk("rst_cfg", {cfg_applied, frame_count}, 0);
      tick(300, 300, 1'b0, 1'b0);
      rst_n = 1'b1;

      for (int k = 0; k < 12; k++) begin
         tick(1100, 780, pat[k], 1'b0);
         if (k >= 3) chk("hs_delay", hs_o, pat[k-3]);
      end

      // Window at (200,250), scale 0.
      x0 = 11'd200; y0 = 10'd250;
      new_frame(16'd1);
      for (int h = 196; h <= 446; h++) begin
         tick(h, 250, 1'b0, 1'b0);
         if (h == 199) chk("ren_before_win", fb_if.ren_out, 0);
         if (h == 200) chk("addr_first", {fb_if.ren_out, fb_if.raddr_out}, {1'b1, 17'd0});
         if (h == 203) chk("rgb_first", rgb, 12'h000);
         if (h == 206) chk("rgb_203", rgb, 12'h333);
         if (h == 439) chk("addr_last", {fb_if.ren_out, fb_if.raddr_out}, {1'b1, 17'd239});
         if (h == 440) chk("addr_hold", {fb_if.ren_out, fb_if.raddr_out}, {1'b0, 17'd239});
         if (h == 442) chk("rgb_439", rgb, 12'hFFF);
         if (h == 443) chk("rgb_no_border", rgb, 12'h000);
      end

      // Mid-frame x0 change must not take effect before vsync.
      x0 = 11'd300;
      for (int h = 196; h <= 205; h++) begin
         tick(h, 251, 1'b0, 1'b0);
         if (h == 200) chk("midframe_addr", {fb_if.ren_out, fb_if.raddr_out}, {1'b1, 17'd240});
      end
      chk("midframe_nopulse", cfg_applied, 0);
      new_frame(16'd2);
      for (int h = 296; h <= 310; h++) begin
         tick(h, 250, 1'b0, 1'b0);
         if (h == 299) chk("x300_before", fb_if.ren_out, 0);
         if (h == 300) chk("x300_first", {fb_if.ren_out, fb_if.raddr_out}, {1'b1, 17'd0});
         if (h == 305) chk("x300_addr5", fb_if.raddr_out, 5);
      end

      // Scale 1 at the origin.
      x0 = '0; y0 = '0; scale = 2'd1;
      new_frame(16'd3);
      for (int h = 0; h <= 490; h++) begin
         tick(h, 0, 1'b0, 1'b0);
         if (h == 0) chk("s1_h0", {fb_if.ren_out, fb_if.raddr_out}, {1'b1, 17'd0});
         if (h == 1) chk("s1_h1", fb_if.raddr_out, 0);
         if (h == 2) chk("s1_h2", fb_if.raddr_out, 1);
         if (h == 479) chk("s1_h479", {fb_if.ren_out, fb_if.raddr_out}, {1'b1, 17'd239});
         if (h == 480) chk("s1_end", fb_if.ren_out, 0);
      end
      tick(0, 2, 1'b0, 1'b0);
      chk("s1_line2", fb_if.raddr_out, 240);

      // Mirror, scale 0.
      scale = 2'd0; mirror = 1'b1;
      new_frame(16'd4);
      for (int h = 0; h <= 241; h++) begin
         tick(h, 0, 1'b0, 1'b0);
         if (h == 0) chk("mir_h0", fb_if.raddr_out, 239);
         if (h == 239) chk("mir_h239", fb_if.raddr_out, 0);
         if (h == 240) chk("mir_end", fb_if.ren_out, 0);
      end
      tick(5, 3, 1'b0, 1'b0);
      chk("mir_v3h5", fb_if.raddr_out, 954);

      // Out-of-range scale clamps to 2.
      mirror = 1'b0; scale = 2'd3;
      new_frame(16'd5);
      for (int h = 0; h <= 965; h++) begin
         tick(h, 4, 1'b0, 1'b0);
         if (h == 3) chk("clamp_h3", fb_if.raddr_out, 240);
         if (h == 4) chk("clamp_h4", fb_if.raddr_out, 241);
         if (h == 959) chk("clamp_h959", {fb_if.ren_out, fb_if.raddr_out}, {1'b1, 17'd479});
         if (h == 960) chk("clamp_end", fb_if.ren_out, 0);
      end

      // Border and overlay around the (200,250) window.
      scale = 2'd0; x0 = 11'd200; y0 = 10'd250; border_en = 1'b1;
      new_frame(16'd6);
      for (int h = 196; h <= 206; h++) begin
         overlay_valid = (h == 199);
         tick(h, 250, 1'b0, 1'b0);
         if (h == 201) chk("no_border_198", rgb, 12'h000);
         if (h == 202) chk("overlay_199", rgb, 12'h5A3);
      end
      overlay_valid = 1'b0;
      for (int h = 196; h <= 446; h++) begin
         tick(h, 251, 1'b0, 1'b0);
         if (h == 202) chk("border_left", rgb, 12'hFFF);
         if (h == 204) chk("win_201_251", rgb, 12'h111);
         if (h == 443) chk("border_right", rgb, 12'hFFF);
         if (h == 444) chk("outside_441", rgb, 12'h000);
      end
      for (int h = 296; h <= 303; h++) begin
         tick(h, 249, 1'b0, 1'b0);
         if (h == 303) chk("border_top", rgb, 12'hFFF);
      end

      // Window clipped at the right edge of the active area.
      border_en = 1'b0; x0 = 11'd1000; y0 = '0;
      new_frame(16'd7);
      for (int h = 1018; h <= 1100; h++) begin
         tick(h, 5, 1'b0, 1'b0);
         if (h == 1023) chk("clip_last", {fb_if.ren_out, fb_if.raddr_out}, {1'b1, 17'd1223});
         if (h == 1024) chk("clip_1024", {fb_if.ren_out, fb_if.raddr_out}, {1'b0, 17'd1223});
         if (h == 1026) chk("clip_rgb", rgb, 12'h777);
         if (h == 1100) chk("clip_1100", {fb_if.ren_out, fb_if.raddr_out}, {1'b0, 17'd1223});
      end

      x0 = 11'd1100;
      new_frame(16'd8);
      for (int h = 1018; h <= 1030; h++) begin
         tick(h, 5, 1'b0, 1'b0);
         if (h == 1023) chk("offscreen_x0", fb_if.ren_out, 0);
      end

      // Mid-frame reset: config returns to the origin, output refills after L cycles.
      rst_n = 1'b0;
      tick(10, 0, 1'b0, 1'b0);
      chk("midrst_rgb", rgb, 0);
      chk("midrst_cfg", {fb_if.ren_out, frame_count}, 0);
      rst_n = 1'b1;
      for (int h = 3; h <= 6; h++) begin
         tick(h, 0, 1'b0, 1'b0);
         if (h == 3) chk("midrst_addr", {fb_if.ren_out, fb_if.raddr_out}, {1'b1, 17'd3});
         if (h == 5) chk("midrst_blank", rgb, 12'h000);
         if (h == 6) chk("midrst_first", rgb, 12'h333);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_window_compositor.md
Name: gray_window_compositor

Overview:
- Parametrised display-side compositor that places a grayscale frame-buffer image at a programmable window on the VGA raster.
- Generalises the fixed offset, fixed scale and hand-built sync pipelines of the display path into one block with:
  - runtime offset, integer scale and mirror, all frame-synchronous;
  - a configurable BRAM read latency;
  - a built-in, matched sync/blank delay line;
  - an optional border and a sprite overlay.
- Sits between the vga timing generator / frame buffer read port and the vga_r/g/b, vga_hs/vga_vs pins, on the 65 MHz domain.

Parameters:
- H_ACTIVE, 1024, active pixels per line.
- V_ACTIVE, 768, active lines per frame.
- IMG_W, 240, stored image width in pixels.
- IMG_H, 320, stored image height in lines.
- ADDR_W, 17, frame buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- PIX_W, 4, grayscale bits per pixel and bits per output colour channel.
- RAM_LAT, 2, read latency of the frame buffer in cycles (1..4).
- SCALE_MAX, 2, largest accepted log2 scale.
- BORDER_GRAY, 4'hF, border intensity, PIX_W bits.

Ports:
- clk_in  input  1  65 MHz pixel clock.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- hcount_in  input  11  raster x from the vga timing generator.
- vcount_in  input  10  raster y from the vga timing generator.
- hsync_in  input  1  active-high hsync, pre-inversion.
- vsync_in  input  1  active-high vsync, pre-inversion.
- blank_in  input  1  high outside the active area.
- x0_in  input  11  requested window left edge.
- y0_in  input  10  requested window top edge.
- scale_in  input  2  requested log2 magnification.
- mirror_in  input  1  requested horizontal mirror.
- border_en_in  input  1  draw a 1-pixel border around the window.
- overlay_in  input  3*PIX_W  overlay RGB pixel, aligned to hcount_in/vcount_in.
- overlay_valid_in  input  1  overlay pixel is opaque.
- raddr_out  output  ADDR_W  frame buffer read address.
- ren_out  output  1  frame buffer read enable.
- rdata_in  input  PIX_W  frame buffer read data, valid RAM_LAT cycles after raddr_out.
- r_out, g_out, b_out  output  PIX_W each  colour channels.
- hsync_out, vsync_out  output  1 each  delayed syncs, still active-high; inverted at the pins.
- cfg_applied_out  output  1  one-cycle pulse when the shadow config is loaded.
- frame_count_out  output  16  count of vsync_in rising edges, wraps.

Behaviour:
- Reset: asynchronous, active-low, single clock clk_in.
  - All outputs go to 0.
  - Active config goes to x0=0, y0=0, scale=0, mirror=0.
  - The delay line clears to 0, so the reset state reads as blank with no sync.
- Config shadowing:
  - x0_in, y0_in, scale_in and mirror_in are sampled only on the cycle after a vsync_in rising edge.
  - On that cycle cfg_applied_out pulses and frame_count_out increments.
  - Mid-frame input changes have no effect.
  - scale_in > SCALE_MAX is clamped to SCALE_MAX.
- Stage A (registered):
  - dx = hcount_in - x0; dy = vcount_in - y0.
  - in_win = hcount_in >= x0 && hcount_in < x0+(IMG_W<<s) && vcount_in >= y0 && vcount_in < y0+(IMG_H<<s) && !blank_in.
  - Comparisons use 12-bit arithmetic; there is no wrap-around.
  - u = dx>>s; v = dy>>s.
  - With mirror, u = IMG_W-1-u.
  - raddr_out = v*IMG_W + u.
  - ren_out = in_win.
  - raddr_out holds its previous value when in_win=0.
- Border flag: set when border_en_in is high, the pixel is not in_win, is inside the active area, and lies within the 1-pixel ring surrounding the window.
- Delay line: in_win, the border flag, overlay, blank, hsync and vsync are delayed by RAM_LAT so they align with rdata_in.
- Output stage (registered), in priority order:
  - blank → 0;
  - overlay_valid → overlay;
  - in_win → {rdata_in, rdata_in, rdata_in};
  - border → BORDER_GRAY on all channels;
  - otherwise 0.
- Total latency from hcount_in to r/g/b_out is L = RAM_LAT+2 cycles. hsync_out and vsync_out are delayed by exactly L.
- Clipping:
  - A window extending past H_ACTIVE or V_ACTIVE is clipped; no reads occur for off-screen positions.
  - x0 >= H_ACTIVE produces zero reads for the whole frame.
- Simultaneous events: a vsync edge and reset together → reset wins.
- Reset mid-frame: the output is blank until the delay line refills. The first valid pixel appears L cycles after release.

Test Plan:
- Reset, then free-run a raster with RAM_LAT=2 → outputs 0 during reset. hsync_out equals hsync_in delayed by 4 cycles.
- x0=200, y0=250, scale=0, RAM model returns addr[3:0] → at hcount=200, vcount=250: raddr_out=0, and r_out=0 four cycles later. At hcount=439, vcount=250: raddr_out=239. At hcount=440: ren_out=0.
- scale=1, x0=0, y0=0 → hcount 0..1 both read address 0; hcount 2 reads address 1; line 2 reads address 240; the window ends at hcount 480.
- mirror=1, scale=0, x0=0 → hcount=0 reads address 239; hcount=239 reads address 0.
- Change x0_in from 200 to 300 mid-frame → addresses are unchanged until the vsync rising edge. cfg_applied_out pulses once, frame_count_out increments by 1, and the next frame starts at hcount=300.
- border_en=1 with overlay_valid asserted at (199,250) → the output is the overlay colour. At (199,251) with no overlay → all channels 4'hF. x0=1000, scale=0 → raddr_out stays fixed and ren_out never asserts beyond hcount 1023.
